// File: rtl/spi_slave_rx_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/slave pair.
//   DEFAULT_DATA_WIDTH : frame width used by both ends of the link
//   SPI_CPOL/SPI_CPHA  : SPI mode 0 (idle-low SCLK, sample on rising edge)
//   state_t            : receive FSM state encoding
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;

   localparam bit SPI_CPOL = 1'b0;
   localparam bit SPI_CPHA = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      WAIT_CS = 2'd2
   } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_if
// Parallel-side bundle of the SPI receiver.
//   rx_data   : last completed word
//   rx_valid  : word available, held until accepted
//   rx_ack    : consumer accepts the word
//   overrun   : sticky, a word was overwritten before being accepted
//   frame_err : one-cycle pulse on a malformed frame
//   bit_count : bits received in the current frame
//   busy      : receiver is inside a frame
// Modports:
//   master : the receiver, which produces words
//   slave  : the consumer, which acknowledges them
// ---------------------------------------------------------------------------
interface spi_slave_rx_if #(
   parameter int DATA_WIDTH = spi_pkg::DEFAULT_DATA_WIDTH,
   parameter int CNT_W      = 5
) ();

   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ack;
   logic                  overrun;
   logic                  frame_err;
   logic [CNT_W-1:0]      bit_count;
   logic                  busy;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ack,
      output overrun,
      output frame_err,
      output bit_count,
      output busy
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ack,
      input  overrun,
      input  frame_err,
      input  bit_count,
      input  busy
   );

endinterface

// File: rtl/spi_slave_rx_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser followed by one history flop for edge detection.
//   clk   : local clock
//   reset : asynchronous, active-low
//   din   : asynchronous input pin
//   dout  : synchronised level
//   rise  : one-cycle pulse, synchronised level went 0 -> 1
//   fall  : one-cycle pulse, synchronised level went 1 -> 0
// RESET_VAL presets every flop, so a pin already at the opposite level when
// reset is released produces a clean edge.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg <= {SYNC_STAGES{RESET_VAL}};
         prev_reg <= RESET_VAL;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign dout = sync_reg[SYNC_STAGES-1];
   assign rise = dout & ~prev_reg;
   assign fall = ~dout & prev_reg;

endmodule

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
// SPI mode-0 receiver: oversamples CS/SCLK/MOSI in the clk domain, shifts
// bits MSB-first on rising SCLK and hands each completed word to a
// valid/ack holding register.
//   clk      : system clock
//   reset    : asynchronous, active-low
//   spi_cs_l : chip select from master, active-low
//   spi_sclk : serial clock from master
//   spi_data : serial data (MOSI), MSB first
//   rx_if    : parallel word/handshake/status bundle (master modport)
// ---------------------------------------------------------------------------
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           spi_cs_l,
   input  logic           spi_sclk,
   input  logic           spi_data,
   spi_slave_rx_if.master rx_if
);

   // Conditioned SPI inputs; unused edge outputs carry an _unused suffix.
   logic cs_rise, cs_fall, cs_level_unused;
   logic sclk_rise, sclk_level_unused, sclk_fall_unused;
   logic data_s, data_rise_unused, data_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk   (clk),
      .reset (reset),
      .din   (spi_cs_l),
      .dout  (cs_level_unused),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .din   (spi_sclk),
      .dout  (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall_unused)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
      .clk   (clk),
      .reset (reset),
      .din   (spi_data),
      .dout  (data_s),
      .rise  (data_rise_unused),
      .fall  (data_fall_unused)
   );

   state_t                state_reg,     state_next;
   logic [DATA_WIDTH-1:0] shift_reg,     shift_next;
   logic [CNT_W-1:0]      bit_count_reg, bit_count_next;
   logic                  frame_err_reg, frame_err_next;
   // Completion is flagged one cycle after the last shift, so the holding
   // stage loads the fully shifted word.
   logic                  word_done_reg, word_done_next;
   logic [DATA_WIDTH-1:0] rx_data_reg,   rx_data_next;
   logic                  rx_valid_reg,  rx_valid_next;
   logic                  overrun_reg,   overrun_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         bit_count_reg <= '0;
         frame_err_reg <= 1'b0;
         word_done_reg <= 1'b0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         bit_count_reg <= bit_count_next;
         frame_err_reg <= frame_err_next;
         word_done_reg <= word_done_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         overrun_reg   <= overrun_next;
      end
   end

   // Frame FSM and shift register
   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      bit_count_next = bit_count_reg;
      frame_err_next = 1'b0;
      word_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cs_fall) begin
               shift_next     = '0;
               bit_count_next = '0;
               state_next     = SHIFT;
            end
         end

         SHIFT: begin
            // CS release wins over a coincident SCLK edge; that edge is dropped.
            if (cs_rise) begin
               frame_err_next = 1'b1;
               bit_count_next = '0;
               state_next     = IDLE;
            end else if (sclk_rise) begin
               shift_next     = {shift_reg[DATA_WIDTH-2:0], data_s};
               bit_count_next = bit_count_reg + CNT_W'(1);
               if (bit_count_reg == CNT_W'(DATA_WIDTH - 1)) begin
                  word_done_next = 1'b1;
                  state_next     = WAIT_CS;
               end
            end
         end

         WAIT_CS: begin
            if (cs_rise) begin
               bit_count_next = '0;
               state_next     = IDLE;
            end else if (sclk_rise) begin
               frame_err_next = 1'b1;
            end
         end

         default: begin
            bit_count_next = '0;
            state_next     = IDLE;
         end
      endcase
   end

   // Holding stage: a completing word always wins over a same-cycle ack.
   always_comb begin
      rx_data_next  = rx_data_reg;
      rx_valid_next = rx_valid_reg;
      overrun_next  = overrun_reg;

      if (word_done_reg) begin
         rx_data_next  = shift_reg;
         rx_valid_next = 1'b1;
         if (rx_valid_reg && rx_if.rx_ack) begin
            overrun_next = 1'b0;
         end else if (rx_valid_reg) begin
            overrun_next = 1'b1;
         end
      end else if (rx_valid_reg && rx_if.rx_ack) begin
         rx_valid_next = 1'b0;
         overrun_next  = 1'b0;
      end
   end

   assign rx_if.rx_data   = rx_data_reg;
   assign rx_if.rx_valid  = rx_valid_reg;
   assign rx_if.overrun   = overrun_reg;
   assign rx_if.frame_err = frame_err_reg;
   assign rx_if.bit_count = bit_count_reg;
   assign rx_if.busy      = (state_reg != IDLE);

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side counterpart of the team's 16-bit SPI master (`spi_protocol`). It receives serial frames that the master drives on `spi_cs_l`, `spi_sclk` and `spi_data`.
- All three SPI inputs are oversampled in the local `clk` domain. Bits are captured MSB-first on rising `spi_sclk` (SPI mode 0).
- Each completed word is presented on a parallel valid/ack holding register.
- The block sits at the peripheral end of the link. It also acts as the loop-back checker for the master in system benches.

Parameters:
- DATA_WIDTH, 16, bits per frame; also the width of `rx_data`.
- SYNC_STAGES, 2, flip-flop stages on each SPI input (minimum 2).
- CNT_W, 5, width of `bit_count`; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- spi_cs_l  input  1  chip select from master, active-low.
- spi_sclk  input  1  serial clock from master.
- spi_data  input  1  serial data (MOSI), MSB first.
- rx_data  output  DATA_WIDTH  last completed word; held stable while `rx_valid`=1.
- rx_valid  output  1  word available; held until accepted.
- rx_ack  input  1  consumer accepts word; sampled only when `rx_valid`=1.
- overrun  output  1  sticky; a new word completed while `rx_valid`=1.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- bit_count  output  CNT_W  bits received in current frame (0..DATA_WIDTH).
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE; rx_data=0; rx_valid=0; overrun=0; frame_err=0; bit_count=0; busy=0.
  - shift register=0.
  - synchronisers preset: cs_l=1, sclk=0, data=0.
- Input conditioning:
  - Each SPI input passes through SYNC_STAGES flops, then one history flop for edge detection.
  - sclk_rise = synced sclk high and previous value low.
  - cs_fall and cs_rise are defined the same way on synced `spi_cs_l`.
  - `spi_sclk` high and low phases must each be ≥ 2 `clk` periods; faster SCLK is out of spec.
- State IDLE:
  - cs_fall: clear shift register and bit_count, go to SHIFT.
  - sclk_rise while IDLE is ignored.
- State SHIFT, on sclk_rise:
  - shift_reg = {shift_reg[DATA_WIDTH-2:0], synced data}; bit_count increments.
  - When bit_count reaches DATA_WIDTH, the same cycle loads the completed word into the holding stage (next cycle) and goes to WAIT_CS.
- State SHIFT, on cs_rise with bit_count < DATA_WIDTH:
  - frame_err pulses one cycle; partial word is discarded.
  - bit_count clears; go to IDLE.
- Holding stage, on word completion:
  - rx_data = new word; rx_valid=1.
  - If rx_valid was already 1 and not acked this cycle: overwrite rx_data and set overrun=1.
  - Latency: rx_valid asserts 1 `clk` after the synced sclk_rise of bit DATA_WIDTH, i.e. SYNC_STAGES+2 `clk` edges after the raw pin edge.
- Handshake:
  - rx_valid=1 and rx_ack=1 at a clk edge: rx_valid clears next cycle and overrun clears.
  - Same-cycle completion and ack: the new word wins; rx_valid stays 1 and overrun is not set.
  - rx_ack while rx_valid=0 has no effect.
- State WAIT_CS:
  - cs_rise: bit_count clears; go to IDLE.
  - sclk_rise (extra clocks beyond DATA_WIDTH): frame_err pulses once per extra edge; data is ignored and bit_count stays at DATA_WIDTH.
- Simultaneous cs_rise and sclk_rise: cs_rise takes priority and the edge is not sampled.
- Back-to-back frames: a cs_fall in the cycle after cs_rise is legal; IDLE accepts it immediately.
- Reset mid-frame: everything returns to reset values immediately, and the partial word is lost.
  - After reset release with `spi_cs_l` already low, the preset synchronisers produce a cs_fall. The block enters SHIFT and counts from 0.

Decomposition:
- Shared package `spi_pkg` holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, WAIT_CS=2'd2;
  - default DATA_WIDTH=16 and SPI mode constant (CPOL=0, CPHA=0), shared with `spi_protocol`.
- One sub-module, `spi_sync_edge`: a parameterised SYNC_STAGES synchroniser with rise/fall outputs, instantiated three times. Its reset preset value is a parameter.
- The FSM, shift register and holding stage stay in `spi_slave_rx`.

Test Plan:
- Master loop-back: `spi_protocol` sending 16'h5555, slave rx_ack tied high → rx_valid pulses once per frame with rx_data=16'h5555; frame_err=0, overrun=0.
- Data change: 16'h5555 then 16'h1234 → consecutive rx_data values 16'h5555 then 16'h1234; bit_count steps 0..16 then returns to 0 on cs_rise.
- Short frame: 8 SCLK pulses (0xA5) then `spi_cs_l` high → one-cycle frame_err; rx_valid stays 0; bit_count returns to 0.
- Overrun: rx_ack=0, frames 16'hBEEF then 16'hCAFE → rx_data=16'hCAFE, overrun=1; one rx_ack cycle → rx_valid=0, overrun=0.
- Extra clocks: 18 SCLK pulses in one frame, first 16 bits 16'h00FF → rx_data=16'h00FF; exactly 2 frame_err pulses.
- Reset mid-frame: reset=0 after 7 bits of 16'hFFFF, released with CS low, then 16 bits of 16'h0F0F → all outputs 0 during reset; a clean word 16'h0F0F follows.
